// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
// Load handshake between user logic and the seven-segment scan driver.
//   value       : four hex digits, [3:0] is the rightmost digit
//   dp_in       : decimal point enable per digit, 1 = lit
//   blank_in    : per-digit blank, 1 = anode never asserted
//   lz_suppress : leading-zero suppression enable
//   load        : single-cycle strobe capturing the four fields above
//   pending     : high while captured data waits for the frame boundary
// master = user logic side, slave = display driver side.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;
    logic        load;
    logic        pending;

    modport master (
        output value, dp_in, blank_in, lz_suppress, load,
        input  pending
    );

    modport slave (
        input  value, dp_in, blank_in, lz_suppress, load,
        output pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a four-digit common-anode seven-segment
// display. Each digit slot starts with a dark guard interval to avoid
// ghosting. New data is captured on load and committed only at the end of
// a frame, so a frame never mixes old and new digits.
// Ports:
//   clk         : master clock
//   reset_n     : asynchronous active-low reset
//   bus         : load handshake (value, dp_in, blank_in, lz_suppress, load, pending)
//   frame_start : one-cycle pulse on the first output cycle of each digit-0 slot
//   an          : anodes, active-low
//   seg         : segments, active-low, [6:0] = g..a, [7] = decimal point
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    seg7_scan_driver_if.slave   bus,
    output logic                frame_start,
    output logic [3:0]          an,
    output logic [7:0]          seg
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    digit;

    logic [15:0] pend_value;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_blank;
    logic        pend_lz;
    logic        pending_q;

    logic [15:0] sh_value;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;
    logic        sh_lz;

    logic        commit;
    logic [3:0]  nib;
    logic [3:0]  suppress;
    logic [3:0]  an_next;
    logic [7:0]  seg_next;

    assign bus.pending = pending_q;
    assign commit      = (cnt == CNT_LAST) && (digit == 2'd3);

    // Active-low hex font, bits g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot counter and digit index; the digit advances when a slot wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture into the pending bank; at the frame boundary move data into
    // the shadow bank. A load landing on the boundary bypasses the pending
    // bank so the very next frame shows it and pending never rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= 4'hF;
            pend_lz    <= 1'b0;
            pending_q  <= 1'b0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blank   <= 4'hF;
            sh_lz      <= 1'b0;
        end else if (commit) begin
            pending_q <= 1'b0;
            if (bus.load) begin
                sh_value <= bus.value;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
                sh_lz    <= bus.lz_suppress;
            end else if (pending_q) begin
                sh_value <= pend_value;
                sh_dp    <= pend_dp;
                sh_blank <= pend_blank;
                sh_lz    <= pend_lz;
            end
        end else if (bus.load) begin
            pend_value <= bus.value;
            pend_dp    <= bus.dp_in;
            pend_blank <= bus.blank_in;
            pend_lz    <= bus.lz_suppress;
            pending_q  <= 1'b1;
        end
    end

    // A digit is a leading zero when it and every higher nibble are zero;
    // digit 0 always shows so a zero value still reads "0".
    always_comb begin
        suppress    = 4'b0000;
        suppress[3] = sh_lz && (sh_value[15:12] == 4'h0);
        suppress[2] = suppress[3] && (sh_value[11:8] == 4'h0);
        suppress[1] = suppress[2] && (sh_value[7:4] == 4'h0);
    end

    // Next anode/segment pattern for the current (digit, cnt) position.
    // Blanked or unlit positions drive all segments dark as well.
    always_comb begin
        an_next  = 4'hF;
        seg_next = 8'hFF;
        nib      = sh_value[{digit, 2'b00} +: 4];
        if (cnt >= CNT_GUARD && !sh_blank[digit]) begin
            if (suppress[digit]) begin
                seg_next = {~sh_dp[digit], 7'h7F};
                if (sh_dp[digit]) begin
                    an_next[digit] = 1'b0;
                end
            end else begin
                seg_next       = {~sh_dp[digit], hex_to_seg(nib)};
                an_next[digit] = 1'b0;
            end
        end
    end

    // Registered outputs, one cycle behind the slot state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= 4'hF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= seg_next;
            frame_start <= (digit == 2'd0) && (cnt == '0);
        end
    end

endmodule
